div_unit: RTL

Iterative signed integer divider for the multdiv datapath. Accepts a dividend/divisor pair on a one-cycle start strobe and runs non-restoring division, one quotient bit per cycle. All add/subtract steps go through a single instance of the team's carry-lookahead adder built from 8-bit CLA blocks, so this block drives that adder's operands and consumes its sum every cycle. Quotient, remainder and a divide-by-zero flag are presented with a one-cycle ready pulse.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_unit_cla.sv | 61 ++++++
 rtl/div_unit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative signed divider.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX,
        DONE
    } div_state_e;

endpackage

// File: rtl/div_unit_cla.sv
// Two-level carry-lookahead adder: 8-bit CLA blocks whose group P/G feed the
// block-carry chain. WIDTH must be a multiple of 8.
module cla_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [NB-1:0]    blk_p;
    logic [NB-1:0]    blk_g;
    logic [NB:0]      blk_c;
    logic             grp_g;
    logic             bit_c;

    assign p = a_i ^ b_i;
    assign g = a_i & b_i;

    // NOTE: every variable gets a default before the loops, so no path through
    // this block leaves one unassigned and no latch is inferred.
    always_comb begin
        blk_p = '0;
        blk_g = '0;
        blk_c = '0;
        sum_o = '0;
        grp_g = 1'b0;
        bit_c = 1'b0;

        for (int k = 0; k < NB; k++) begin
            blk_p[k] = &p[8*k +: 8];
            grp_g = 1'b0;
            for (int i = 0; i < 8; i++) begin
                grp_g = g[8*k+i] | (p[8*k+i] & grp_g);
            end
            blk_g[k] = grp_g;
        end

        blk_c[0] = cin_i;
        for (int k = 0; k < NB; k++) begin
            blk_c[k+1] = blk_g[k] | (blk_p[k] & blk_c[k]);
        end

        for (int k = 0; k < NB; k++) begin
            bit_c = blk_c[k];
            for (int i = 0; i < 8; i++) begin
                sum_o[8*k+i] = p[8*k+i] ^ bit_c;
                bit_c        = g[8*k+i] | (p[8*k+i] & bit_c);
            end
        end
    end

    assign cout_o = blk_c[NB];

endmodule

// File: rtl/div_unit.sv
// Iterative signed non-restoring divider, one quotient bit per cycle, with all
// iteration add/subtract steps through one shared CLA adder.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int CNT_W = (WIDTH == DIV_WIDTH) ? DIV_CNT_W : $clog2(WIDTH);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;

    logic [WIDTH:0]   r_sh;
    logic [WIDTH-1:0] add_a, add_b, add_sum;
    logic             add_cin, add_cout, a_top, b_top, do_sub;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   r_fix;

    assign r_sh = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

    // FIX restores a negative remainder; ITER adds or subtracts D by the old sign.
    always_comb begin
        do_sub  = 1'b0;
        add_a   = r_sh[WIDTH-1:0];
        add_b   = d_q;
        add_cin = 1'b0;
        a_top   = r_sh[WIDTH];
        b_top   = 1'b0;
        if (state_q == FIX) begin
            add_a = r_q[WIDTH-1:0];
            a_top = r_q[WIDTH];
        end else begin
            do_sub  = ~r_q[WIDTH];
            add_b   = do_sub ? ~d_q : d_q;
            add_cin = do_sub;
            b_top   = do_sub;
        end
    end

    cla_adder #(.WIDTH(WIDTH)) u_cla (
        .a_i    (add_a),
        .b_i    (add_b),
        .cin_i  (add_cin),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    assign sum_ext = {a_top ^ b_top ^ add_cout, add_sum};
    assign r_fix   = r_q[WIDTH] ? sum_ext : r_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        r_d      = r_q;
        q_d      = q_q;
        d_d      = d_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        rem_d    = rem_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;

        if (ctrl_DIV) begin
            q_d    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
            d_d    = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
            qneg_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            rneg_d = data_operandA[WIDTH-1];
            r_d    = '0;
            cnt_d  = '0;
            if (data_operandB == '0) begin
                state_d  = DONE;
                result_d = '0;
                rem_d    = '0;
                exc_d    = 1'b1;
                rdy_d    = 1'b1;
            end else begin
                state_d = ITER;
            end
        end else begin
            case (state_q)
                ITER: begin
                    r_d   = sum_ext;
                    q_d   = {q_q[WIDTH-2:0], ~sum_ext[WIDTH]};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
                end
                FIX: begin
                    result_d = qneg_q ? -q_q : q_q;
                    rem_d    = rneg_q ? -r_fix[WIDTH-1:0] : r_fix[WIDTH-1:0];
                    exc_d    = 1'b0;
                    rdy_d    = 1'b1;
                    state_d  = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: the datapath registers are reset along with the control state so a
    // reset mid-operation leaves nothing stale behind; they are plain flops, not memory.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            r_q      <= '0;
            q_q      <= '0;
            d_q      <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            rem_q    <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            r_q      <= r_d;
            q_q      <= q_d;
            d_q      <= d_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_remainder = rem_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule
